datapath_ctrl: RTL and testbench
================================

Name: datapath_ctrl

Overview:
- Parametrised successor to the lab datapath: a register file, A/B/C pipeline registers, shifter and ALU, now driven by an integrated multi-cycle controller FSM.
- Accepts one command per start/ready handshake.
- Executes the command through load-A, load-B, ALU and writeback states, and reports N/V/Z status.
- Sits between the instruction decoder (future CPU top) and the register state; a debug read port is provided for benches.

Parameters:
- WIDTH, 16, datapath word width in bits (>= 4).
- NREGS, 8, number of general registers (power of 2, >= 2).
- RBITS, $clog2(NREGS), register index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- s  in  1  start; sampled only while w=1.
- op  in  3  command: 000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN; others are NOP.
- shift  in  2  applied to Rm: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
- rd  in  RBITS  destination register.
- rn  in  RBITS  first operand register.
- rm  in  RBITS  second (shifted) operand register.
- imm  in  WIDTH  immediate for MOVI.
- w  out  1  idle/ready; high only in WAIT.
- done  out  1  one-cycle pulse when a command retires.
- datapath_out  out  WIDTH  C register.
- N, V, Z  out  1 each  status flags (registered).
- dbg_addr  in  RBITS  debug read index.
- dbg_data  out  WIDTH  combinational R[dbg_addr].

Behaviour:
- Command capture: op/shift/rd/rn/rm/imm are latched when s=1 in WAIT. Later input changes have no effect on the running command.
- Reset (synchronous, clk edge with reset=1):
  - state WAIT; all NREGS registers, A, B and C cleared to 0.
  - N=V=Z=0, done=0, w=1.
  - Reset overrides s and aborts any in-flight command with no writeback.
- States: WAIT, LDA, LDB, ALU, WB, WIMM.
  - MOVI: WAIT -> WIMM (R[rd]<=imm) -> WAIT.
  - MOV: WAIT -> LDB -> ALU (C <= 0 + sh(B); flags unchanged) -> WB -> WAIT.
  - ADD, AND: WAIT -> LDA -> LDB -> ALU -> WB -> WAIT.
  - CMP: WAIT -> LDA -> LDB -> ALU (flags only; C unchanged) -> WAIT.
  - MVN: WAIT -> LDB -> ALU (C <= ~sh(B)) -> WB -> WAIT.
  - NOP: WAIT -> WAIT with done pulse; no state change.
- Register transfers: LDA: A<=R[rn]. LDB: B<=R[rm]. WB: R[rd]<=C.
- Latency: the edge that sees s is edge 0. The final state's edge returns the FSM to WAIT and sets done=1 for exactly one cycle.
  - Busy cycles: MOVI 1, MOV 3, ADD 4, AND 4, CMP 3, MVN 3, NOP 0 (done on the edge after s).
- w=0 in every non-WAIT state. s is ignored while w=0, and back-to-back commands are not queued.
- s may be asserted in the same cycle done=1 (the FSM is in WAIT); the new command starts on that edge.
- Shifter:
  - LSL1 shifts in 0.
  - LSR1 shifts in 0 at the MSB.
  - ASR1 replicates the MSB.
  - Shift applies to the B path only.
- ALU arithmetic and flags:
  - All arithmetic is modulo 2^WIDTH.
  - ADD = A+sh(B); CMP = A-sh(B).
  - Z = (result==0); N = result[WIDTH-1].
  - V = signed overflow for ADD/CMP, V=0 for AND/MVN.
  - Flags update on the ALU edge for ADD, CMP, AND, MVN only.
- Hazards: rd may equal rn or rm. Reads always happen in earlier states than WB, so the old value is used.
- dbg_data is combinational and reflects writes from the edge just taken.

Test Plan:
- Reset then MOVI R0=0x0007, MOVI R1=0x0002 -> each takes 1 busy cycle with a done pulse; dbg R0=0x0007, R1=0x0002.
- ADD rd=R2, rn=R1, rm=R0, shift=01 -> w low 4 cycles; R2=0x0010, datapath_out=0x0010, N=0, V=0, Z=0.
- CMP rn=R0, rm=R0, shift=00 -> Z=1, N=0, V=0; datapath_out stays 0x0010; no register written; 3 busy cycles.
- MOVI R3=0x7FFF, R4=0x0001; ADD R5=R3+R4 -> R5=0x8000, N=1, V=1, Z=0. Then MVN R6, rm=R5, shift=11 -> R6=0x3FFF, N=0, V=0.
- s pulsed during a busy ADD with op=MOVI, rd=R0, imm=0xFFFF -> ignored; R0 unchanged; exactly one done pulse.
- Assert reset during the LDB cycle of an ADD to R2 -> next cycle w=1, done=0, R2=0x0000, flags 0. Repeat the bench with WIDTH=8, NREGS=4: ADD 0x7F+0x01 -> 0x80, V=1.

Source files
------------

// File: rtl/datapath_ctrl.sv
// Register-file datapath with A/B/C pipeline registers, B-path shifter and ALU,
// sequenced by a multi-cycle controller that runs one command per start handshake.
module datapath_ctrl #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREGS = 8,
   parameter int unsigned RBITS = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s,
   input  logic [2:0]       op,
   input  logic [1:0]       shift,
   input  logic [RBITS-1:0] rd,
   input  logic [RBITS-1:0] rn,
   input  logic [RBITS-1:0] rm,
   input  logic [WIDTH-1:0] imm,
   output logic             w,
   output logic             done,
   output logic [WIDTH-1:0] datapath_out,
   output logic             N,
   output logic             V,
   output logic             Z,
   input  logic [RBITS-1:0] dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   localparam logic [2:0] OpMovi = 3'b000;
   localparam logic [2:0] OpMov  = 3'b001;
   localparam logic [2:0] OpAdd  = 3'b010;
   localparam logic [2:0] OpCmp  = 3'b011;
   localparam logic [2:0] OpAnd  = 3'b100;
   localparam logic [2:0] OpMvn  = 3'b101;

   typedef enum logic [2:0] {StWait, StLda, StLdb, StAlu, StWb, StWimm} state_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_done_next;
   logic [2:0]         r_op;
   logic [1:0]         r_shift;
   logic [RBITS-1:0]   r_rd;
   logic [RBITS-1:0]   r_rn;
   logic [RBITS-1:0]   r_rm;
   logic [WIDTH-1:0]   r_imm;
   logic [WIDTH-1:0]   r_regs [NREGS];
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_c;
   logic               r_n;
   logic               r_v;
   logic               r_z;
   logic               r_done;

   logic [WIDTH-1:0]   w_bsh;
   logic [WIDTH-1:0]   w_sum;
   logic [WIDTH-1:0]   w_diff;
   logic [WIDTH-1:0]   w_res;
   logic               w_v;
   logic               w_upd_flags;
   logic               w_wr_c;

   // Next-state and done generation; the command decision in WAIT uses the live op.
   always_comb begin
      w_next      = r_state;
      w_done_next = 1'b0;
      unique case (r_state)
         StWait: begin
            if (s) begin
               unique case (op)
                  OpMovi:               w_next = StWimm;
                  OpMov, OpMvn:         w_next = StLdb;
                  OpAdd, OpCmp, OpAnd:  w_next = StLda;
                  default:              w_done_next = 1'b1;
               endcase
            end
         end
         StLda: w_next = StLdb;
         StLdb: w_next = StAlu;
         StAlu: begin
            if (r_op == OpCmp) begin
               w_next      = StWait;
               w_done_next = 1'b1;
            end else begin
               w_next = StWb;
            end
         end
         StWb, StWimm: begin
            w_next      = StWait;
            w_done_next = 1'b1;
         end
         default: w_next = StWait;
      endcase
   end

   always_comb begin
      w_bsh = r_b;
      unique case (r_shift)
         2'b00: w_bsh = r_b;
         2'b01: w_bsh = {r_b[WIDTH-2:0], 1'b0};
         2'b10: w_bsh = {1'b0, r_b[WIDTH-1:1]};
         2'b11: w_bsh = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
         default: w_bsh = r_b;
      endcase
   end

   assign w_sum  = r_a + w_bsh;
   assign w_diff = r_a - w_bsh;

   // MOV writes C but leaves flags alone; CMP updates flags but leaves C alone.
   always_comb begin
      w_res       = '0;
      w_v         = 1'b0;
      w_upd_flags = 1'b0;
      w_wr_c      = 1'b0;
      unique case (r_op)
         OpAdd: begin
            w_res       = w_sum;
            w_v         = (r_a[WIDTH-1] == w_bsh[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            w_upd_flags = 1'b1;
            w_wr_c      = 1'b1;
         end
         OpCmp: begin
            w_res       = w_diff;
            w_v         = (r_a[WIDTH-1] != w_bsh[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            w_upd_flags = 1'b1;
         end
         OpAnd: begin
            w_res       = r_a & w_bsh;
            w_upd_flags = 1'b1;
            w_wr_c      = 1'b1;
         end
         OpMvn: begin
            w_res       = ~w_bsh;
            w_upd_flags = 1'b1;
            w_wr_c      = 1'b1;
         end
         OpMov: begin
            w_res  = w_bsh;
            w_wr_c = 1'b1;
         end
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StWait;
         r_done  <= 1'b0;
         r_op    <= '0;
         r_shift <= '0;
         r_rd    <= '0;
         r_rn    <= '0;
         r_rm    <= '0;
         r_imm   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= '0;
         r_n     <= 1'b0;
         r_v     <= 1'b0;
         r_z     <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         r_state <= w_next;
         r_done  <= w_done_next;
         unique case (r_state)
            StWait: begin
               if (s) begin
                  r_op    <= op;
                  r_shift <= shift;
                  r_rd    <= rd;
                  r_rn    <= rn;
                  r_rm    <= rm;
                  r_imm   <= imm;
               end
            end
            StLda: r_a <= r_regs[r_rn];
            StLdb: r_b <= r_regs[r_rm];
            StAlu: begin
               if (w_wr_c) begin
                  r_c <= w_res;
               end
               if (w_upd_flags) begin
                  r_n <= w_res[WIDTH-1];
                  r_v <= w_v;
                  r_z <= (w_res == '0);
               end
            end
            StWb:   r_regs[r_rd] <= r_c;
            StWimm: r_regs[r_rd] <= r_imm;
            default: r_done <= 1'b0;
         endcase
      end
   end

   assign w            = (r_state == StWait);
   assign done         = r_done;
   assign datapath_out = r_c;
   assign N            = r_n;
   assign V            = r_v;
   assign Z            = r_z;
   assign dbg_data     = r_regs[dbg_addr];

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: a 16-bit/8-reg instance and an 8-bit/4-reg instance
// share command inputs; expectations are queued at issue and checked on each done pulse.
`timescale 1ns/1ps
module tb_datapath_ctrl;

   localparam logic [2:0] OpMovi = 3'b000;
   localparam logic [2:0] OpMov  = 3'b001;
   localparam logic [2:0] OpAdd  = 3'b010;
   localparam logic [2:0] OpCmp  = 3'b011;
   localparam logic [2:0] OpAnd  = 3'b100;
   localparam logic [2:0] OpMvn  = 3'b101;
   localparam logic [2:0] OpNop  = 3'b110;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        s16 = 1'b0;
   logic        s8 = 1'b0;
   logic [2:0]  op = '0;
   logic [1:0]  shift = '0;
   logic [2:0]  rd = '0;
   logic [2:0]  rn = '0;
   logic [2:0]  rm = '0;
   logic [2:0]  dbg_addr = '0;
   logic [15:0] imm = '0;

   logic        w16, done16, n16, v16, z16;
   logic [15:0] c16, dbg16;
   logic        w8, done8, n8, v8, z8;
   logic [7:0]  c8, dbg8;

   always #5 clk = ~clk;

   datapath_ctrl #(.WIDTH(16), .NREGS(8)) dut16 (
      .clk(clk), .reset(reset), .s(s16), .op(op), .shift(shift),
      .rd(rd), .rn(rn), .rm(rm), .imm(imm),
      .w(w16), .done(done16), .datapath_out(c16), .N(n16), .V(v16), .Z(z16),
      .dbg_addr(dbg_addr), .dbg_data(dbg16)
   );

   datapath_ctrl #(.WIDTH(8), .NREGS(4)) dut8 (
      .clk(clk), .reset(reset), .s(s8), .op(op), .shift(shift),
      .rd(rd[1:0]), .rn(rn[1:0]), .rm(rm[1:0]), .imm(imm[7:0]),
      .w(w8), .done(done8), .datapath_out(c8), .N(n8), .V(v8), .Z(z8),
      .dbg_addr(dbg_addr[1:0]), .dbg_data(dbg8)
   );

   typedef struct {
      string       name;
      logic [15:0] c;
      logic [2:0]  f;     // {N,V,Z}
      logic [15:0] d;     // expected dbg_data at retire
      int          busy;
   } exp_t;

   exp_t q16[$];
   exp_t q8[$];
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic mon_check(input string tag, input exp_t e, input logic [15:0] c,
                            input logic [2:0] f, input logic [15:0] d, input int busy);
      check({tag, e.name, " out"}, 32'(c), 32'(e.c));
      check({tag, e.name, " nvz"}, 32'(f), 32'(e.f));
      check({tag, e.name, " dbg"}, 32'(d), 32'(e.d));
      check({tag, e.name, " busy"}, 32'(busy), 32'(e.busy));
   endtask

   task automatic monitor();
      int   b16 = 0;
      int   b8 = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            b16 = 0;
            b8  = 0;
         end else begin
            if (!w16) b16++;
            if (!w8) b8++;
            if (done16) begin
               if (q16.size() == 0) begin
                  check("dut16 done with empty queue", 32'(done16), 32'h0);
               end else begin
                  e = q16.pop_front();
                  mon_check("dut16 ", e, c16, {n16, v16, z16}, dbg16, b16);
               end
               b16 = 0;
            end
            if (done8) begin
               if (q8.size() == 0) begin
                  check("dut8 done with empty queue", 32'(done8), 32'h0);
               end else begin
                  e = q8.pop_front();
                  mon_check("dut8 ", e, {8'h00, c8}, {n8, v8, z8}, {8'h00, dbg8}, b8);
               end
               b8 = 0;
            end
         end
      end
   endtask

   task automatic drive(input bit sel8, input logic [2:0] o, input logic [1:0] sh,
                        input logic [2:0] d, input logic [2:0] n, input logic [2:0] m,
                        input logic [15:0] im, input logic [2:0] dbg);
      @(posedge clk);
      #1;
      op = o; shift = sh; rd = d; rn = n; rm = m; imm = im; dbg_addr = dbg;
      if (sel8) s8 = 1'b1;
      else s16 = 1'b1;
      @(posedge clk);
      #1;
      s8  = 1'b0;
      s16 = 1'b0;
   endtask

   task automatic wait_empty(input bit sel8, input string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((sel8 ? q8.size() : q16.size()) == 0) return;
      end
      check({name, " retire timeout, queue depth"}, 32'(sel8 ? q8.size() : q16.size()), 32'h0);
      if (sel8) q8.delete();
      else q16.delete();
   endtask

   task automatic push(input bit sel8, input string name, input logic [15:0] c,
                       input logic [2:0] f, input logic [15:0] d, input int busy);
      exp_t e;
      e.name = name; e.c = c; e.f = f; e.d = d; e.busy = busy;
      if (sel8) q8.push_back(e);
      else q16.push_back(e);
   endtask

   task automatic run(input bit sel8, input string name, input logic [2:0] o,
                      input logic [1:0] sh, input logic [2:0] d, input logic [2:0] n,
                      input logic [2:0] m, input logic [15:0] im, input logic [2:0] dbg,
                      input logic [15:0] ec, input logic [2:0] ef, input logic [15:0] ed,
                      input int eb);
      push(sel8, name, ec, ef, ed, eb);
      drive(sel8, o, sh, d, n, m, im, dbg);
      wait_empty(sel8, name);
   endtask

   initial begin
      fork
         monitor();
      join_none

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset w16", 32'(w16), 32'h1);
      check("reset done16", 32'(done16), 32'h0);
      check("reset out16", 32'(c16), 32'h0);
      check("reset nvz16", 32'({n16, v16, z16}), 32'h0);
      check("reset dbg16 r0", 32'(dbg16), 32'h0);
      check("reset w8", 32'(w8), 32'h1);
      check("reset out8", 32'(c8), 32'h0);

      //   sel name        op      sh     rd    rn    rm    imm       dbg   out       nvz     dbg      busy
      run(0, "movi r0",  OpMovi, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0007, 3'd0, 16'h0000, 3'b000, 16'h0007, 1);
      run(0, "movi r1",  OpMovi, 2'b00, 3'd1, 3'd0, 3'd0, 16'h0002, 3'd1, 16'h0000, 3'b000, 16'h0002, 1);
      run(0, "add r2",   OpAdd,  2'b01, 3'd2, 3'd1, 3'd0, 16'h0000, 3'd2, 16'h0010, 3'b000, 16'h0010, 4);
      run(0, "cmp r0r0", OpCmp,  2'b00, 3'd7, 3'd0, 3'd0, 16'h0000, 3'd7, 16'h0010, 3'b001, 16'h0000, 3);
      run(0, "movi r3",  OpMovi, 2'b00, 3'd3, 3'd0, 3'd0, 16'h7FFF, 3'd3, 16'h0010, 3'b001, 16'h7FFF, 1);
      run(0, "movi r4",  OpMovi, 2'b00, 3'd4, 3'd0, 3'd0, 16'h0001, 3'd4, 16'h0010, 3'b001, 16'h0001, 1);
      run(0, "add r5",   OpAdd,  2'b00, 3'd5, 3'd3, 3'd4, 16'h0000, 3'd5, 16'h8000, 3'b110, 16'h8000, 4);
      run(0, "mvn r6",   OpMvn,  2'b11, 3'd6, 3'd0, 3'd5, 16'h0000, 3'd6, 16'h3FFF, 3'b000, 16'h3FFF, 3);
      run(0, "mov r7",   OpMov,  2'b10, 3'd7, 3'd0, 3'd1, 16'h0000, 3'd7, 16'h0001, 3'b000, 16'h0001, 3);
      run(0, "and r2",   OpAnd,  2'b01, 3'd2, 3'd2, 3'd4, 16'h0000, 3'd2, 16'h0000, 3'b001, 16'h0000, 4);
      run(0, "nop",      OpNop,  2'b00, 3'd2, 3'd0, 3'd0, 16'h0000, 3'd2, 16'h0000, 3'b001, 16'h0000, 0);

      // A start pulse in the middle of a busy ADD must be dropped entirely.
      push(0, "add r0 busy-s", 16'h000E, 3'b000, 16'h000E, 4);
      drive(0, OpAdd, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000, 3'd0);
      @(posedge clk);
      #1;
      op = OpMovi; rd = 3'd0; imm = 16'hFFFF; s16 = 1'b1;
      @(posedge clk);
      #1 s16 = 1'b0;
      wait_empty(0, "add r0 busy-s");
      repeat (6) @(negedge clk);
      check("ignored movi r0", 32'(dbg16), 32'h000E);

      run(0, "movi r2",  OpMovi, 2'b00, 3'd2, 3'd0, 3'd0, 16'h55AA, 3'd2, 16'h000E, 3'b000, 16'h55AA, 1);
      run(0, "cmp r2r2", OpCmp,  2'b00, 3'd2, 3'd2, 3'd2, 16'h0000, 3'd2, 16'h000E, 3'b001, 16'h55AA, 3);

      // Abort an ADD to R2 with reset while it sits in LDB.
      @(posedge clk);
      #1;
      op = OpAdd; shift = 2'b00; rd = 3'd2; rn = 3'd2; rm = 3'd2; dbg_addr = 3'd2; s16 = 1'b1;
      @(posedge clk);
      #1 s16 = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort w16", 32'(w16), 32'h1);
      check("abort done16", 32'(done16), 32'h0);
      check("abort r2", 32'(dbg16), 32'h0);
      check("abort nvz16", 32'({n16, v16, z16}), 32'h0);
      check("abort out16", 32'(c16), 32'h0);
      repeat (6) @(negedge clk);

      run(1, "w8 movi r0", OpMovi, 2'b00, 3'd0, 3'd0, 3'd0, 16'h007F, 3'd0, 16'h0000, 3'b000, 16'h007F, 1);
      run(1, "w8 movi r1", OpMovi, 2'b00, 3'd1, 3'd0, 3'd0, 16'h0001, 3'd1, 16'h0000, 3'b000, 16'h0001, 1);
      run(1, "w8 add r2",  OpAdd,  2'b00, 3'd2, 3'd0, 3'd1, 16'h0000, 3'd2, 16'h0080, 3'b110, 16'h0080, 4);
      run(1, "w8 mvn r3",  OpMvn,  2'b11, 3'd3, 3'd0, 3'd2, 16'h0000, 3'd3, 16'h003F, 3'b000, 16'h003F, 3);

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
